// File: rtl/spi_peripheral_pkg.sv
// Shared definitions for the SPI register-write target: register addresses,
// frame length and the frame-handling FSM state type.
package uwasic_spi_pkg;

    // Register map seen by pwm_peripheral
    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    // One R/W bit, seven address bits, eight data bits
    localparam int FRAME_BITS = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_peripheral_sync.sv
// Multi-stage synchronizer for one asynchronous pin, with single-cycle
// rise/fall pulses taken between the last synced stage and one delay flop.
// STAGES must be at least 2. RST_VAL is the idle level of the pin so that
// leaving reset does not fabricate an edge.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              dly_q;
    logic              dly_d;

    // Next state: shift the pin into the chain, delay the last stage by one
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
        dly_d  = sync_q[STAGES-1];
    end

    // Synchronizer and delay flops, reset to the pin's idle level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-1] & ~dly_q;
    assign fall = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 target that accepts 16-bit register-write frames and drives the
// five control registers read by pwm_peripheral. All SPI pins are treated as
// asynchronous and oversampled on clk, so sclk phases must each last at least
// four clk periods.
// Optional build macro SPI_READBACK_EN: frames with R/W = 0 return the
// addressed register on cipo; without it cipo is tied low.
module spi_peripheral #(
    parameter int FRAME_BITS  = uwasic_spi_pkg::FRAME_BITS,
    parameter int MAX_ADDR    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    import uwasic_spi_pkg::*;

    // Counter reaches FRAME_BITS+1 to flag an overlong frame
    localparam int                CNT_W      = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_OVER   = CNT_W'(FRAME_BITS + 1);
    localparam logic [6:0]        MAX_ADDR_L = 7'(MAX_ADDR);

    logic sclk_s, sclk_rise, sclk_fall;
    logic copi_s, copi_rise, copi_fall;
    logic ncs_s, ncs_rise, ncs_fall;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk  (clk),
        .rst_n(rst_n),
        .d_in (sclk),
        .q    (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk  (clk),
        .rst_n(rst_n),
        .d_in (copi),
        .q    (copi_s),
        .rise (copi_rise),
        .fall (copi_fall)
    );

    // nCS idles high, so its synchronizer resets high
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk  (clk),
        .rst_n(rst_n),
        .d_in (ncs),
        .q    (ncs_s),
        .rise (ncs_rise),
        .fall (ncs_fall)
    );

    // Synchronizer outputs not needed in every build
    logic unused_sync;
    assign unused_sync = ^{sclk_s, sclk_fall, copi_rise, copi_fall, ncs_s};

    spi_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic                  fall_pend_q, fall_pend_d;
    logic [7:0]            en_out_lo_q, en_out_lo_d;
    logic [7:0]            en_out_hi_q, en_out_hi_d;
    logic [7:0]            en_pwm_lo_q, en_pwm_lo_d;
    logic [7:0]            en_pwm_hi_q, en_pwm_hi_d;
    logic [7:0]            duty_q, duty_d;

    logic [6:0]            frame_addr;
    logic [7:0]            frame_data;
    logic                  frame_ok;

    assign frame_addr = shreg_q[FRAME_BITS-2 -: 7];
    assign frame_data = shreg_q[7:0];
    // Only an exact-length write to a mapped address is committed
    assign frame_ok   = (cnt_q == CNT_FULL) && shreg_q[FRAME_BITS-1] &&
                        (frame_addr <= MAX_ADDR_L);

    // Frame FSM: collect bits while nCS is low, then commit for one cycle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        fall_pend_d = fall_pend_q;
        en_out_lo_d = en_out_lo_q;
        en_out_hi_d = en_out_hi_q;
        en_pwm_lo_d = en_pwm_lo_q;
        en_pwm_hi_d = en_pwm_hi_q;
        duty_d      = duty_q;

        case (state_q)
            IDLE: begin
                if (ncs_fall || fall_pend_q) begin
                    state_d     = SHIFT;
                    cnt_d       = '0;
                    shreg_d     = '0;
                    fall_pend_d = 1'b0;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_d = COMMIT;
                end else if (sclk_rise) begin
                    shreg_d = {shreg_q[FRAME_BITS-2:0], copi_s};
                    if (cnt_q != CNT_OVER) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
                // A frame start seen here is replayed in the following IDLE cycle
                if (ncs_fall) begin
                    fall_pend_d = 1'b1;
                end
                if (frame_ok) begin
                    case (frame_addr)
                        ADDR_EN_OUT_LO: en_out_lo_d = frame_data;
                        ADDR_EN_OUT_HI: en_out_hi_d = frame_data;
                        ADDR_EN_PWM_LO: en_pwm_lo_d = frame_data;
                        ADDR_EN_PWM_HI: en_pwm_hi_d = frame_data;
                        ADDR_DUTY:      duty_d      = frame_data;
                        default:        ;
                    endcase
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, frame capture and register flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            fall_pend_q <= 1'b0;
            en_out_lo_q <= 8'h00;
            en_out_hi_q <= 8'h00;
            en_pwm_lo_q <= 8'h00;
            en_pwm_hi_q <= 8'h00;
            duty_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            fall_pend_q <= fall_pend_d;
            en_out_lo_q <= en_out_lo_d;
            en_out_hi_q <= en_out_hi_d;
            en_pwm_lo_q <= en_pwm_lo_d;
            en_pwm_hi_q <= en_pwm_hi_d;
            duty_q      <= duty_d;
        end
    end

    assign en_reg_out_7_0  = en_out_lo_q;
    assign en_reg_out_15_8 = en_out_hi_q;
    assign en_reg_pwm_7_0  = en_pwm_lo_q;
    assign en_reg_pwm_15_8 = en_pwm_hi_q;
    assign pwm_duty_cycle  = duty_q;

`ifdef SPI_READBACK_EN
    logic [7:0] tx_q, tx_d;
    logic [7:0] rd_byte;
    logic [7:0] rd_val;

    // Read side: load the addressed register after the 8th rising edge,
    // hold its MSB through rising edge 9, then shift on each falling edge
    always_comb begin
        tx_d    = tx_q;
        rd_byte = {shreg_q[6:0], copi_s};
        rd_val  = 8'h00;
        if (rd_byte[6:0] <= MAX_ADDR_L) begin
            case (rd_byte[6:0])
                ADDR_EN_OUT_LO: rd_val = en_out_lo_q;
                ADDR_EN_OUT_HI: rd_val = en_out_hi_q;
                ADDR_EN_PWM_LO: rd_val = en_pwm_lo_q;
                ADDR_EN_PWM_HI: rd_val = en_pwm_hi_q;
                ADDR_DUTY:      rd_val = duty_q;
                default:        rd_val = 8'h00;
            endcase
        end

        if (state_q == IDLE) begin
            if (ncs_fall || fall_pend_q) begin
                tx_d = 8'h00;
            end
        end else if (state_q == SHIFT && !ncs_rise) begin
            if (sclk_rise && cnt_q == CNT_W'(7)) begin
                tx_d = rd_byte[7] ? 8'h00 : rd_val;
            end else if (sclk_fall && cnt_q >= CNT_W'(9)) begin
                tx_d = {tx_q[6:0], 1'b0};
            end
        end
    end

    // Transmit shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= 8'h00;
        end else begin
            tx_q <= tx_d;
        end
    end

    assign cipo = ncs_s ? 1'b0 : tx_q[7];
`else
    assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
`timescale 1ns/1ps
module tb_spi_peripheral;

    localparam int SYNC = 2;
    localparam int HALF = 5;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk  = 1'b0;
    logic       copi  = 1'b0;
    logic       ncs   = 1'b1;
    logic       cipo;
    logic [7:0] r_out_lo, r_out_hi, r_pwm_lo, r_pwm_hi, r_duty;

    spi_peripheral #(
        .FRAME_BITS (16),
        .MAX_ADDR   (4),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sclk           (sclk),
        .copi           (copi),
        .ncs            (ncs),
        .cipo           (cipo),
        .en_reg_out_7_0 (r_out_lo),
        .en_reg_out_15_8(r_out_hi),
        .en_reg_pwm_7_0 (r_pwm_lo),
        .en_reg_pwm_15_8(r_pwm_hi),
        .pwm_duty_cycle (r_duty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference register file: what the controller believes it has written
    logic [7:0] model [0:4];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_out_lo"}, r_out_lo, model[0]);
        chk({tag, "_out_hi"}, r_out_hi, model[1]);
        chk({tag, "_pwm_lo"}, r_pwm_lo, model[2]);
        chk({tag, "_pwm_hi"}, r_pwm_hi, model[3]);
        chk({tag, "_duty"},   r_duty,   model[4]);
        chk({tag, "_cipo"},   {7'b0, cipo}, 8'h00);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A frame counts only if it is exactly 16 bits, a write, and mapped
    function automatic void model_apply(input logic [31:0] frame, input int nbits);
        logic [6:0] a;
        a = frame[14:8];
        if (nbits == 16 && frame[15] && a <= 7'd4) model[int'(a)] = frame[7:0];
    endfunction

    function automatic logic [7:0] model_read(input logic [6:0] a);
        return (a <= 7'd4) ? model[int'(a)] : 8'h00;
    endfunction

    // Mode-0 controller; ends on the negedge at which nCS is raised.
    // abort_at >= 0 pulses rst_n after that bit's falling sclk edge.
    task automatic spi_xfer(input logic [31:0] frame, input int nbits,
                            input int abort_at, output logic [7:0] rx);
        rx  = 8'h00;
        ncs = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            copi = frame[nbits-1-i];
            wait_clk(HALF);
            if (i >= 8 && i < 16) rx[15-i] = cipo;
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
            if (i == abort_at) begin
                rst_n = 1'b0;
                wait_clk(5);
                rst_n = 1'b1;
                for (int k = 0; k < 5; k++) model[k] = 8'h00;
            end
        end
        wait_clk(HALF);
        ncs  = 1'b1;
        copi = 1'b0;
    endtask

    // Write with the commit latency checked: unchanged one cycle early, updated on time
    task automatic timed_write(input logic [15:0] frame, input string tag);
        logic [7:0] rx;
        spi_xfer({16'h0, frame}, 16, -1, rx);
        wait_clk(SYNC + 1);
        check_regs({tag, "_early"});
        model_apply({16'h0, frame}, 16);
        wait_clk(1);
        check_regs({tag, "_ontime"});
    endtask

    task automatic plain_frame(input logic [31:0] frame, input int nbits, input string tag);
        logic [7:0] rx;
        spi_xfer(frame, nbits, -1, rx);
        model_apply(frame, nbits);
        wait_clk(8);
        check_regs(tag);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rx;
        logic [31:0] frame;
        logic [6:0]  addr;
        logic        rw;
        int          nbits;
        int          pick;

        for (int k = 0; k < 5; k++) model[k] = 8'h00;

        // Reset
        rst_n = 1'b0;
        wait_clk(5);
        check_regs("reset");
        rst_n = 1'b1;
        wait_clk(3);

        // Basic writes with latency
        timed_write(16'h80FF, "wr_a0");
        timed_write(16'h8455, "wr_a4");

        // Unmapped, short and overlong frames
        plain_frame(32'h0000_85AA, 16, "unmapped");
        plain_frame(32'h0000_8233 >> 1, 15, "short15");
        plain_frame({15'h0, 16'h8233, 1'b1}, 17, "long17");

        // Reset in the middle of a frame
        timed_write(16'h83C3, "wr_a3");
        spi_xfer(32'h0000_8300, 16, 9, rx);
        wait_clk(8);
        check_regs("abort");

        // Back-to-back frames with a 4-clk nCS high gap
        spi_xfer(32'h0000_8201, 16, -1, rx);
        model_apply(32'h0000_8201, 16);
        wait_clk(4);
        check_regs("b2b_first");
        spi_xfer(32'h0000_8202, 16, -1, rx);
        model_apply(32'h0000_8202, 16);
        wait_clk(8);
        check_regs("b2b_second");

        // sclk activity with nCS high, then an nCS glitch
        for (int k = 0; k < 20; k++) begin
            copi = k[0];
            sclk = ~sclk;
            wait_clk(HALF);
        end
        sclk = 1'b0;
        copi = 1'b0;
        wait_clk(8);
        check_regs("sclk_ncs_high");
        ncs = 1'b0;
        wait_clk(6);
        ncs = 1'b1;
        wait_clk(8);
        check_regs("ncs_glitch");

        // Randomized frames against the reference model
        for (int n = 0; n < 40; n++) begin
            addr = 7'($urandom_range(0, 7));
            rw   = ($urandom_range(0, 3) != 0);
            pick = $urandom_range(0, 9);
            frame = {16'h0, rw, addr, 8'($urandom)};
            nbits = 16;
            if (pick == 0) begin
                frame = frame >> 1;
                nbits = 15;
            end else if (pick == 1) begin
                frame = {frame[30:0], 1'($urandom)};
                nbits = 17;
            end
`ifdef SPI_READBACK_EN
            if (nbits == 16 && !rw) begin
                logic [7:0] exp_rd;
                exp_rd = model_read(addr);
                spi_xfer(frame, nbits, -1, rx);
                chk("rand_read", rx, exp_rd);
                model_apply(frame, nbits);
                wait_clk(8);
                check_regs("rand");
                continue;
            end
`endif
            plain_frame(frame, nbits, "rand");
        end

`ifdef SPI_READBACK_EN
        // Directed readback
        plain_frame(32'h0000_8137, 16, "rb_write");
        spi_xfer(32'h0000_0100, 16, -1, rx);
        chk("rb_addr1", rx, 8'h37);
        wait_clk(8);
        check_regs("rb_after_read");
        spi_xfer(32'h0000_1000, 16, -1, rx);
        chk("rb_addr10", rx, model_read(7'h10));
        wait_clk(8);
        check_regs("rb_after_unmapped");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
